digit_frame_receiver: RTL and testbench

Far-end receiver for the calculator's digit echo stream. It samples a UART line (8N1, LSB first) and assembles ASCII digit bytes '0'..'9' (0x30..0x39) into a buffer of up to 8 digits. Because the transmitting side sends bare digits with no terminator, a line-idle gap marks the end of a frame. On frame end the block publishes the digits, count and status for one result display or compute stage.

---
 rtl/digit_frame_receiver.sv | 208 ++++++++++++++++++++
 tb/tb_digit_frame_receiver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_frame_receiver.sv
// digit_frame_receiver
//   Far-end UART (8N1, LSB first) receiver for the calculator digit echo
//   stream. ASCII digits are packed into a nibble buffer of up to 8 digits.
//   Frames have no terminator, so a line-idle gap ends a frame and
//   publishes the buffer.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   rxd          asynchronous UART line, idle high
//   digits       frame digits, newest in [3:0], unused nibbles zero
//   count        digits in frame, 0..8
//   frame_valid  one-cycle pulse when the outputs below update
//   frame_error  frame held a non-digit byte or a bad stop bit
//   overflow     frame held more than 8 digits
module digit_frame_receiver #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_BITS     = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic [31:0] digits,
    output logic [3:0]  count,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        overflow
);
    localparam int TW      = $clog2(CLKS_PER_BIT);
    localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    localparam int GW      = $clog2(GAP_CYC);

    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    // Publish on the cycle the gap counter steps to GAP_CYC-1; the registered
    // outputs then appear exactly GAP_CYC cycles after the byte event.
    localparam logic [GW-1:0] GAP_PUB   = GW'(GAP_CYC - 2);

    typedef enum logic [2:0] {R_ARM, R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic {F_IDLE, F_COLLECT} f_state_e;

    // ---------------- synchronizer ----------------
    logic [1:0] sync_q;
    logic       rxs;
    assign rxs = sync_q[1];

    // ---------------- bit receiver ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_ok, byte_bad;

    always_comb begin
        rx_state_d = rx_state_q;
        timer_d    = timer_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;
        case (rx_state_q)
            R_ARM: begin
                timer_d = '0;
                if (rxs) rx_state_d = R_IDLE;
            end
            R_IDLE: begin
                timer_d = '0;
                if (!rxs) rx_state_d = R_START;
            end
            R_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    rx_state_d = rxs ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d   = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (rxs) begin
                        byte_ok    = 1'b1;
                        rx_state_d = R_IDLE;
                    end else begin
                        // Framing error: wait for a high line before hunting
                        // for the next start bit.
                        byte_bad   = 1'b1;
                        rx_state_d = R_ARM;
                    end
                end
            end
            default: rx_state_d = R_ARM;
        endcase
    end

    // ---------------- frame assembler ----------------
    f_state_e      f_state_q, f_state_d;
    logic [31:0]   buf_q, buf_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          err_q, err_d, ovf_q, ovf_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   digits_q, digits_d;
    logic [3:0]    count_q, count_d;
    logic          fv_q, fv_d, ferr_q, ferr_d, fovf_q, fovf_d;
    logic          is_digit, rx_busy;

    assign is_digit = (shift_q[7:4] == 4'h3) && (shift_q[3:0] <= 4'd9);
    // A start edge seen in IDLE counts as busy so it wins over a frame end
    // landing in the same cycle.
    assign rx_busy  = (rx_state_q != R_IDLE) || !rxs;

    always_comb begin
        f_state_d = f_state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        gap_d     = gap_q;
        digits_d  = digits_q;
        count_d   = count_q;
        ferr_d    = ferr_q;
        fovf_d    = fovf_q;
        fv_d      = 1'b0;
        if (byte_ok || byte_bad) begin
            f_state_d = F_COLLECT;
            gap_d     = '0;
            if (f_state_q == F_IDLE) begin
                buf_d = '0;
                cnt_d = '0;
                err_d = 1'b0;
                ovf_d = 1'b0;
            end
            if (byte_ok && is_digit) begin
                buf_d = {buf_d[27:0], shift_q[3:0]};
                if (cnt_d == 4'd8) ovf_d = 1'b1;
                else               cnt_d = cnt_d + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (f_state_q == F_COLLECT) begin
            if (rx_busy) begin
                gap_d = '0;
            end else if (gap_q == GAP_PUB) begin
                digits_d  = buf_q;
                count_d   = cnt_q;
                ferr_d    = err_q;
                fovf_d    = ovf_q;
                fv_d      = 1'b1;
                gap_d     = '0;
                f_state_d = F_IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 2'b00;
            rx_state_q <= R_ARM;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            f_state_q  <= F_IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            gap_q      <= '0;
            digits_q   <= '0;
            count_q    <= '0;
            fv_q       <= 1'b0;
            ferr_q     <= 1'b0;
            fovf_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rxd};
            rx_state_q <= rx_state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            f_state_q  <= f_state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            gap_q      <= gap_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            fv_q       <= fv_d;
            ferr_q     <= ferr_d;
            fovf_q     <= fovf_d;
        end
    end

    assign digits      = digits_q;
    assign count       = count_q;
    assign frame_valid = fv_q;
    assign frame_error = ferr_q;
    assign overflow    = fovf_q;

endmodule

// File: tb/tb_digit_frame_receiver.sv
module tb_digit_frame_receiver;
    localparam int CPB      = 16;
    localparam int GAP      = 4;
    localparam int GC       = GAP * CPB;
    // Longest idle after a stop bit whose following start still joins the frame.
    localparam int MAX_IDLE = GC - CPB / 2 - 1;
    // Start edge on rxd -> frame_valid, for a frame ending in a good byte.
    localparam int FV_LAT   = 2 + CPB / 2 + 9 * CPB + GC;

    logic        clk = 1'b0;
    logic        reset, rxd;
    logic [31:0] digits;
    logic [3:0]  count;
    logic        frame_valid, frame_error, overflow;

    digit_frame_receiver #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .digits(digits), .count(count),
        .frame_valid(frame_valid), .frame_error(frame_error), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // frame_valid monitor
    int          fv_cyc[$];
    logic [31:0] fv_dig[$];
    logic [3:0]  fv_cnt[$];
    logic        fv_err[$], fv_ovf[$];
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cyc.push_back(cyc);
            fv_dig.push_back(digits);
            fv_cnt.push_back(count);
            fv_err.push_back(frame_error);
            fv_ovf.push_back(overflow);
        end
    end

    // current frame contents: byte and stop-bit value
    logic [7:0] fb[$];
    logic       fs[$];

    // Called at a negedge; returns at a negedge after the idle time.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int idle, output int start_cyc);
        start_cyc = cyc;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic wait_fv(input int n);
        int k = 0;
        while (fv_cyc.size() < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("fv_seen", 32'(fv_cyc.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] ed, input logic [3:0] ec,
                               input logic ee, input logic eo, input int ecyc);
        if (fv_cyc.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_digits"}, fv_dig.pop_front(), ed);
        chk({tag, "_count"},  32'(fv_cnt.pop_front()), 32'(ec));
        chk({tag, "_error"},  32'(fv_err.pop_front()), 32'(ee));
        chk({tag, "_ovf"},    32'(fv_ovf.pop_front()), 32'(eo));
        if (ecyc >= 0) chk({tag, "_cycle"}, 32'(fv_cyc.pop_front()), 32'(ecyc));
        else void'(fv_cyc.pop_front());
    endtask

    // Reference: fold the frame's bytes by the digit rules.
    task automatic model(output logic [31:0] ed, output logic [3:0] ec, output logic ee, output logic eo);
        int n = 0;
        ed = '0; ee = 1'b0;
        foreach (fb[i]) begin
            if (!fs[i] || fb[i] < 8'h30 || fb[i] > 8'h39) ee = 1'b1;
            else begin
                n++;
                ed = (ed << 4) | 32'(fb[i] - 8'h30);
            end
        end
        ec = (n > 8) ? 4'd8 : 4'(n);
        eo = (n > 8);
    endtask

    task automatic send_frame(input string tag);
        int s, last_s, g, ecyc;
        logic [31:0] ed; logic [3:0] ec; logic ee, eo;
        for (int i = 0; i < fb.size(); i++) begin
            if (i == fb.size() - 1) g = 0;
            else begin
                g = ($urandom_range(3) == 0) ? MAX_IDLE : int'($urandom_range(MAX_IDLE));
                if (!fs[i] && g < 4) g = 4;
            end
            send_byte(fb[i], fs[i], g, s);
            last_s = s;
        end
        model(ed, ec, ee, eo);
        ecyc = fs[fb.size() - 1] ? last_s + FV_LAT : -1;
        wait_fv(1);
        check_frame(tag, ed, ec, ee, eo, ecyc);
        repeat ($urandom_range(20, 5)) @(negedge clk);
        chk({tag, "_extra"}, 32'(fv_cyc.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int s1, s2, g, d;
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_digits", digits, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_err", 32'(frame_error), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        fb = '{8'h31, 8'h32, 8'h33}; fs = '{1, 1, 1};
        send_frame("d123");
        fb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30};
        fs = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_frame("dovf");
        fb = '{8'h34, 8'h41, 8'h35}; fs = '{1, 1, 1};
        send_frame("dnon");
        fb = '{8'h37}; fs = '{0};
        send_frame("dbadstop");
        fb = '{8'h37}; fs = '{1};
        send_frame("dafter");

        // Glitch inside the gap: no byte, frame end pushed out.
        send_byte(8'h38, 1'b1, 20, s1);
        g = cyc;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        wait_fv(1);
        d = (fv_cyc.size() > 0) ? fv_cyc[0] - (g + 5) : -1;
        chk("glitch_delay", 32'(d >= GC && d <= GC + CPB / 2 + 2), 32'd1);
        check_frame("glitch", 32'h8, 4'd1, 1'b0, 1'b0, -1);
        repeat (10) @(negedge clk);

        // One cycle past the longest joining idle: two separate frames.
        send_byte(8'h35, 1'b1, MAX_IDLE + 1, s1);
        send_byte(8'h36, 1'b1, 0, s2);
        wait_fv(2);
        check_frame("split_a", 32'h5, 4'd1, 1'b0, 1'b0, s1 + FV_LAT);
        check_frame("split_b", 32'h6, 4'd1, 1'b0, 1'b0, s2 + FV_LAT);
        repeat (10) @(negedge clk);

        // Reset during data bit 6 of the second '9' (0x39).
        send_byte(8'h39, 1'b1, 0, s1);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = s1[0] ? 1'b0 : 1'b0;
            rxd = (8'h39 >> i) & 8'h1;
            if (i == 6) begin
                repeat (8) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                repeat (CPB - 9) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        rxd = 1'b1;
        repeat (300) @(negedge clk);
        chk("rstmid_nofv", 32'(fv_cyc.size()), 32'd0);
        chk("rstmid_digits", digits, 32'd0);
        chk("rstmid_count", 32'(count), 32'd0);
        chk("rstmid_err", 32'(frame_error), 32'd0);
        chk("rstmid_ovf", 32'(overflow), 32'd0);
        fb = '{8'h36}; fs = '{1};
        send_frame("after_rst");

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            int len;
            fb.delete();
            fs.delete();
            len = $urandom_range(11, 1);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(9) < 8) fb.push_back(8'(8'h30 + $urandom_range(9)));
                else fb.push_back(8'($urandom_range(255)));
                fs.push_back($urandom_range(19) != 0);
            end
            send_frame($sformatf("rnd%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
